// File: rtl/dff_reg_arbiter_if.sv
// Request/grant bus between datapath requesters and the shared negative-edge register arbiter.
interface dff_reg_arbiter_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 8
);
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   lock;
  logic [NREQ*W-1:0] wdata;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   ack;
  logic [W-1:0]      q;
  logic              busy;

  modport master (output req, lock, wdata, input gnt, ack, q, busy);
  modport slave  (input req, lock, wdata, output gnt, ack, q, busy);
endinterface

// File: rtl/dff_reg_arbiter.sv
// Round-robin arbiter granting NREQ requesters write access to one shared W-bit
// falling-edge register, with bounded lock bursts.
module dff_reg_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned W       = 8,
  parameter int unsigned MAXHOLD = 8
) (
  input  logic               c,
  input  logic               r,
  dff_reg_arbiter_if.slave   bus
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned HW = 8;

  typedef enum logic [1:0] {IDLE, WRITE, HOLD} state_t;

  state_t          state, state_n;
  logic [PW-1:0]   ptr, ptr_n, owner, owner_n, win;
  logic            found;
  logic [HW-1:0]   hcnt, hcnt_n, hcnt_inc;
  logic [NREQ-1:0] gnt, gnt_n, ack, ack_n;
  logic [W-1:0]    q, q_n, owner_word;
  logic            busy;
  logic            owner_req, owner_lock;

  // First asserted request scanning upward from ptr with wrap.
  always_comb begin : pick
    int unsigned idx;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(ptr) + k) % NREQ;
      if (!found && bus.req[PW'(idx)]) begin
        win   = PW'(idx);
        found = 1'b1;
      end
    end
  end

  assign owner_word = bus.wdata[32'(owner)*W +: W];
  assign owner_req  = bus.req[owner];
  assign owner_lock = bus.lock[owner];
  assign hcnt_inc   = hcnt + HW'(1);

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    owner_n = owner;
    hcnt_n  = hcnt;
    gnt_n   = gnt;
    ack_n   = '0;
    q_n     = q;
    case (state)
      IDLE: begin
        gnt_n = '0;
        if (found) begin
          gnt_n   = NREQ'(1) << win;
          owner_n = win;
          state_n = WRITE;
        end
      end
      WRITE: begin
        ptr_n = (owner == PW'(NREQ-1)) ? '0 : owner + PW'(1);
        if (owner_req) begin
          q_n    = owner_word;
          ack_n  = NREQ'(1) << owner;
          hcnt_n = HW'(1);
          if (owner_lock && (MAXHOLD > 1)) begin
            state_n = HOLD;
          end else begin
            gnt_n   = '0;
            state_n = IDLE;
          end
        end else begin
          gnt_n   = '0;
          state_n = IDLE;
        end
      end
      HOLD: begin
        if (owner_req && owner_lock) begin
          q_n    = owner_word;
          ack_n  = NREQ'(1) << owner;
          hcnt_n = hcnt_inc;
          // Burst length cap keeps other requesters from starving.
          if (hcnt_inc == HW'(MAXHOLD)) begin
            gnt_n   = '0;
            state_n = IDLE;
          end
        end else begin
          gnt_n   = '0;
          state_n = IDLE;
        end
      end
      default: begin
        gnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(negedge c or negedge r) begin
    if (!r) begin
      state <= IDLE;
      ptr   <= '0;
      owner <= '0;
      hcnt  <= '0;
      gnt   <= '0;
      ack   <= '0;
      q     <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      owner <= owner_n;
      hcnt  <= hcnt_n;
      gnt   <= gnt_n;
      ack   <= ack_n;
      q     <= q_n;
      busy  <= (state_n != IDLE);
    end
  end

  assign bus.gnt  = gnt;
  assign bus.ack  = ack;
  assign bus.q    = q;
  assign bus.busy = busy;

endmodule

// File: tb/tb_dff_reg_arbiter.sv
// Scenario bench for dff_reg_arbiter; writes are tracked by an ack/q scoreboard.
module tb_dff_reg_arbiter;

  localparam int unsigned NREQ    = 4;
  localparam int unsigned W       = 8;
  localparam int unsigned MAXHOLD = 3;

  logic c;
  logic r;
  int   checks   = 0;
  int   failures = 0;

  logic [NREQ+W-1:0] exp_q[$];
  logic [NREQ+W-1:0] sb_e;

  dff_reg_arbiter_if #(.NREQ(NREQ), .W(W)) ifc ();

  dff_reg_arbiter #(.NREQ(NREQ), .W(W), .MAXHOLD(MAXHOLD)) dut (
    .c   (c),
    .r   (r),
    .bus (ifc)
  );

  initial c = 1'b1;
  always #5 c = ~c;

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  // DUT updates on the falling edge; outputs are sampled on the rising edge.
  always @(posedge c) begin
    if (r === 1'b1 && ifc.ack !== '0) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_ack got ack=%b q=%h", ifc.ack, ifc.q);
      end else begin
        sb_e = exp_q.pop_front();
        if ({ifc.ack, ifc.q} !== sb_e) begin
          failures++;
          $display("FAIL sb_write got ack=%b q=%h exp ack=%b q=%h",
                   ifc.ack, ifc.q, sb_e[NREQ+W-1:W], sb_e[W-1:0]);
        end
      end
    end
  end

  task automatic push(input logic [NREQ-1:0] a, input logic [W-1:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic set_word(input int i, input logic [W-1:0] d);
    ifc.wdata[i*W +: W] = d;
  endtask

  task automatic cyc();
    @(posedge c);
  endtask

  task automatic test_reset();
    #2;
    checks++; if (ifc.q !== 8'h00)   begin failures++; $display("FAIL rst_init_q got=%h exp=00", ifc.q); end
    checks++; if (ifc.gnt !== 4'b0)  begin failures++; $display("FAIL rst_init_gnt got=%b exp=0000", ifc.gnt); end
    checks++; if (ifc.busy !== 1'b0) begin failures++; $display("FAIL rst_init_busy got=%b exp=0", ifc.busy); end
    cyc();
    r = 1'b1;
    ifc.req = 4'b0010; ifc.lock = 4'b0010; set_word(1, 8'hA5);
    push(4'b0010, 8'hA5);
    cyc();
    checks++; if (ifc.gnt !== 4'b0010) begin failures++; $display("FAIL rst_grant got=%b exp=0010", ifc.gnt); end
    cyc();
    checks++; if (ifc.q !== 8'hA5)     begin failures++; $display("FAIL rst_pre_q got=%h exp=a5", ifc.q); end
    checks++; if (ifc.busy !== 1'b1)   begin failures++; $display("FAIL rst_pre_busy got=%b exp=1", ifc.busy); end
    #1;
    r = 1'b0; ifc.req = '0; ifc.lock = '0;
    #1;
    checks++; if (ifc.q !== 8'h00)   begin failures++; $display("FAIL rst_async_q got=%h exp=00", ifc.q); end
    checks++; if (ifc.gnt !== 4'b0)  begin failures++; $display("FAIL rst_async_gnt got=%b exp=0000", ifc.gnt); end
    checks++; if (ifc.ack !== 4'b0)  begin failures++; $display("FAIL rst_async_ack got=%b exp=0000", ifc.ack); end
    checks++; if (ifc.busy !== 1'b0) begin failures++; $display("FAIL rst_async_busy got=%b exp=0", ifc.busy); end
    cyc();
    checks++; if (ifc.q !== 8'h00) begin failures++; $display("FAIL rst_hold_q got=%h exp=00", ifc.q); end
    r = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] oh;
    set_word(0, 8'h11); set_word(1, 8'h22); set_word(2, 8'h33); set_word(3, 8'h44);
    ifc.req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      oh = 4'b0001 << (i % 4);
      push(oh, 8'h11 * 8'((i % 4) + 1));
    end
    for (int i = 0; i < 5; i++) begin
      oh = 4'b0001 << (i % 4);
      cyc();
      checks++; if (ifc.gnt !== oh) begin failures++; $display("FAIL rr_gnt[%0d] got=%b exp=%b", i, ifc.gnt, oh); end
      cyc();
      checks++; if (ifc.gnt !== 4'b0 || ifc.busy !== 1'b0)
        begin failures++; $display("FAIL rr_idle[%0d] got gnt=%b busy=%b exp gnt=0000 busy=0", i, ifc.gnt, ifc.busy); end
    end
    ifc.req = '0;
    cyc();
  endtask

  task automatic test_single();
    ifc.req = 4'b0100; ifc.lock = '0; set_word(2, 8'h3C);
    push(4'b0100, 8'h3C);
    cyc();
    checks++; if (ifc.gnt !== 4'b0100) begin failures++; $display("FAIL single_gnt got=%b exp=0100", ifc.gnt); end
    checks++; if (ifc.ack !== 4'b0)    begin failures++; $display("FAIL single_ack_early got=%b exp=0000", ifc.ack); end
    cyc();
    checks++; if (ifc.q !== 8'h3C)     begin failures++; $display("FAIL single_q got=%h exp=3c", ifc.q); end
    checks++; if (ifc.gnt !== 4'b0 || ifc.busy !== 1'b0)
      begin failures++; $display("FAIL single_idle got gnt=%b busy=%b exp gnt=0000 busy=0", ifc.gnt, ifc.busy); end
    ifc.req = '0;
    cyc();
    checks++; if (ifc.ack !== 4'b0) begin failures++; $display("FAIL single_ack_pulse got=%b exp=0000", ifc.ack); end
  endtask

  task automatic test_withdraw();
    ifc.req = 4'b1000; set_word(3, 8'h77);
    cyc();
    checks++; if (ifc.gnt !== 4'b1000) begin failures++; $display("FAIL wd_gnt got=%b exp=1000", ifc.gnt); end
    ifc.req = '0;
    cyc();
    checks++; if (ifc.ack !== 4'b0 || ifc.gnt !== 4'b0 || ifc.busy !== 1'b0)
      begin failures++; $display("FAIL wd_end got ack=%b gnt=%b busy=%b exp 0000/0000/0", ifc.ack, ifc.gnt, ifc.busy); end
    checks++; if (ifc.q !== 8'h3C) begin failures++; $display("FAIL wd_q got=%h exp=3c", ifc.q); end
    ifc.req = 4'b1001; set_word(0, 8'h90);
    push(4'b0001, 8'h90);
    cyc();
    checks++; if (ifc.gnt !== 4'b0001) begin failures++; $display("FAIL wd_next_gnt got=%b exp=0001", ifc.gnt); end
    ifc.req = 4'b0001;
    cyc();
    ifc.req = '0;
  endtask

  task automatic test_burst();
    ifc.req = 4'b0011; ifc.lock = 4'b0010; set_word(1, 8'h01); set_word(0, 8'h5A);
    push(4'b0010, 8'h01); push(4'b0010, 8'h02); push(4'b0010, 8'h03); push(4'b0001, 8'h5A);
    cyc();
    checks++; if (ifc.gnt !== 4'b0010) begin failures++; $display("FAIL burst_gnt got=%b exp=0010", ifc.gnt); end
    cyc();
    checks++; if (ifc.gnt !== 4'b0010 || ifc.busy !== 1'b1)
      begin failures++; $display("FAIL burst_hold1 got gnt=%b busy=%b exp 0010/1", ifc.gnt, ifc.busy); end
    set_word(1, 8'h02);
    cyc();
    checks++; if (ifc.gnt !== 4'b0010) begin failures++; $display("FAIL burst_hold2 got=%b exp=0010", ifc.gnt); end
    set_word(1, 8'h03);
    cyc();
    checks++; if (ifc.gnt !== 4'b0 || ifc.busy !== 1'b0)
      begin failures++; $display("FAIL burst_cutoff got gnt=%b busy=%b exp 0000/0", ifc.gnt, ifc.busy); end
    set_word(1, 8'h04);
    cyc();
    checks++; if (ifc.gnt !== 4'b0001) begin failures++; $display("FAIL burst_next_gnt got=%b exp=0001", ifc.gnt); end
    checks++; if (ifc.q !== 8'h03)     begin failures++; $display("FAIL burst_last_q got=%h exp=03", ifc.q); end
    ifc.req = 4'b0001; ifc.lock = '0;
    cyc();
    checks++; if (ifc.gnt !== 4'b0) begin failures++; $display("FAIL burst_next_idle got=%b exp=0000", ifc.gnt); end
    ifc.req = '0;
  endtask

  task automatic test_lock_drop();
    ifc.req = 4'b0100; ifc.lock = 4'b0100; set_word(2, 8'hC1);
    push(4'b0100, 8'hC1); push(4'b0100, 8'hC2);
    cyc();
    checks++; if (ifc.gnt !== 4'b0100) begin failures++; $display("FAIL ld_gnt got=%b exp=0100", ifc.gnt); end
    cyc();
    set_word(2, 8'hC2);
    cyc();
    checks++; if (ifc.gnt !== 4'b0100) begin failures++; $display("FAIL ld_hold got=%b exp=0100", ifc.gnt); end
    ifc.lock = '0; set_word(2, 8'hC3);
    cyc();
    checks++; if (ifc.gnt !== 4'b0 || ifc.ack !== 4'b0 || ifc.busy !== 1'b0)
      begin failures++; $display("FAIL ld_end got gnt=%b ack=%b busy=%b exp 0000/0000/0", ifc.gnt, ifc.ack, ifc.busy); end
    checks++; if (ifc.q !== 8'hC2) begin failures++; $display("FAIL ld_q got=%h exp=c2", ifc.q); end
    ifc.req = '0;
    cyc();
  endtask

  initial begin
    r = 1'b0;
    ifc.req = '0; ifc.lock = '0; ifc.wdata = '0;
    test_reset();
    test_round_robin();
    test_single();
    test_withdraw();
    test_burst();
    test_lock_drop();
    cyc();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover got=%0d pending exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dff_reg_arbiter.md
Name: dff_reg_arbiter

Overview:
- Round-robin arbiter sharing one W-bit negative-edge register among NREQ requesters.
- Each requester presents a write word. The block grants one requester at a time, writes that word into the shared register and returns a one-cycle ack.
- An optional lock lets the owner perform a bounded burst of back-to-back writes.
- Sits between requesting datapath blocks and the shared negative-edge state flops.

Parameters:
- NREQ, 4, number of requesters (2..8)
- W, 8, shared register width
- MAXHOLD, 8, maximum writes per lock burst, counting the first write (1..255)

Ports:
- c  input  1  clock; all state updates on the falling edge of c
- r  input  1  reset, asynchronous, active-low; r=0 clears all state immediately
- req  input  NREQ  per-requester write request, level, held until ack or withdrawn
- lock  input  NREQ  per-requester burst hold; sampled only for the current owner
- wdata  input  NREQ*W  write words; requester i owns bits [i*W +: W]
- gnt  output  NREQ  one-hot grant, registered; all-zero when idle
- ack  output  NREQ  one-hot, one-cycle pulse on the edge where q is written
- q  output  W  shared register contents
- busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset (r=0, asynchronous):
  - state=IDLE; gnt=0; ack=0; q=0; busy=0.
  - Round-robin pointer ptr=0; hold counter hcnt=0.
  - Reset asserted mid-burst aborts the burst; no write completes after r falls.
- Arbitration:
  - Winner is the first asserted req scanning indices ptr, ptr+1, …, NREQ-1, 0, …, ptr-1.
  - ptr width is clog2(NREQ). Wrap is modulo NREQ.
- State IDLE:
  - gnt=0, ack=0.
  - On a falling edge with any req bit set: gnt <= onehot(winner), owner <= winner, state <= WRITE.
- State WRITE (edge after grant):
  - If req[owner]=1:
    - q <= wdata[owner], ack <= onehot(owner), hcnt <= 1.
    - If lock[owner]=1 and MAXHOLD>1: state <= HOLD, gnt held.
    - Otherwise: state <= IDLE, gnt <= 0.
  - If req[owner]=0 (withdrawn): no write, no ack, gnt <= 0, state <= IDLE.
  - In every case ptr <= owner+1 mod NREQ.
- State HOLD, on each edge:
  - If req[owner]=1 and lock[owner]=1:
    - q <= wdata[owner], ack pulse, hcnt <= hcnt+1.
    - If hcnt+1 == MAXHOLD: gnt <= 0, state <= IDLE. The burst is force-terminated; this is the anti-starvation bound.
  - Otherwise: no write, gnt <= 0, state <= IDLE.
- Latency:
  - req rising before edge N gives gnt after edge N.
  - q and ack update after edge N+1.
  - After a non-locked grant the arbiter spends at least one IDLE cycle, so grants are at least 2 cycles apart.
- ack is never asserted in IDLE.
- ack deasserts on the next edge unless a HOLD write occurs there.
- gnt never changes owner without passing through IDLE.
- req of non-owners is ignored until IDLE; their wdata may change freely.
- Simultaneous requests are resolved purely by ptr; no fixed priority.
- lock asserted by a non-owner has no effect.
- Both withdrawn req and withdrawn lock end the burst with no write.
- q holds its value whenever no write occurs.

Test Plan:
- Reset: drive r=0 mid-HOLD with q=8'hA5 -> q=0, gnt=0, ack=0, busy=0 immediately, without waiting for an edge of c.
- Single requester: req=4'b0100, wdata[2]=8'h3C, lock=0 -> gnt=4'b0100 after edge 1; q=8'h3C and ack=4'b0100 after edge 2; gnt=0 and IDLE after edge 2.
- Round-robin fairness: req=4'b1111 held constant, lock=0 -> grant order 0,1,2,3,0; each grant is 2 cycles apart; q follows wdata[0..3] in order.
- Locked burst with MAXHOLD cut-off: MAXHOLD=3, req[1]=lock[1]=1, wdata[1]=1,2,3,4 on successive cycles -> exactly 3 acks with q=1,2,3; gnt drops; req[0], already pending, is granted next.
- Withdrawal: req[3] drops in the WRITE cycle -> no ack, q unchanged, IDLE; ptr advances to 0, so a subsequent req=4'b1001 grants requester 0.
- Lock drop mid-burst: lock[2] goes to 0 after 2 writes -> no third write; gnt=0 on that edge.
